// File: rtl/lfsr_pkg.sv
// Shared types and helpers for the 16-bit XNOR LFSR stream checker.
package lfsr_pkg;

    localparam int unsigned LFSR_W = 16;

    // History indices feeding the prediction (hist[i] = s[n+i]).
    localparam int unsigned TAP_A = 0;
    localparam int unsigned TAP_B = 1;
    localparam int unsigned TAP_C = 3;
    localparam int unsigned TAP_D = 12;

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        HUNT   = 2'd1,
        LOCKED = 2'd2
    } chk_state_t;

    function automatic logic lfsr_next_bit(input logic [LFSR_W-1:0] h);
        return h[TAP_A] ~^ h[TAP_B] ~^ h[TAP_C] ~^ h[TAP_D];
    endfunction

endpackage

// File: rtl/lfsr_checker_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins) and async active-low reset.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/lfsr_checker.sv
// Self-synchronising checker for the 16-bit XNOR LFSR stream with lock tracking and error count.
// Optional statistics outputs (bit_count, lock_losses) are built when LFSR_CHK_STATS_EN is defined.
module lfsr_checker
    import lfsr_pkg::*;
#(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned LOCK_COUNT = 32,
    parameter int unsigned LOSS_COUNT = 8,
    parameter int unsigned ERR_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             clear_err,
    output logic             locked,
    output logic [1:0]       state,
    output logic             err_pulse,
`ifdef LFSR_CHK_STATS_EN
    output logic [31:0]      bit_count,
    output logic [7:0]       lock_losses,
`endif
    output logic [ERR_W-1:0] err_count
);

    localparam int unsigned FILL_W = 5;
    localparam int unsigned CNT_W  = 8;

    chk_state_t         state_q, state_d;
    logic [WIDTH-1:0]   hist_q, hist_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic [CNT_W-1:0]   match_q, match_d;
    logic [CNT_W-1:0]   miss_q, miss_d;
    logic               pulse_d;
    logic               err_inc;
    logic               exp_bit;
    logic               lockup;

    assign exp_bit = lfsr_next_bit(hist_q);
    assign lockup  = &hist_q;

    // Next-state and datapath decisions for one sampled bit.
    always_comb begin
        state_d = state_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        match_d = match_q;
        miss_d  = miss_q;
        pulse_d = 1'b0;
        err_inc = 1'b0;
        if (in_valid) begin
            unique case (state_q)
                FILL: begin
                    hist_d = {in_bit, hist_q[WIDTH-1:1]};
                    fill_d = fill_q + FILL_W'(1);
                    if (fill_q == FILL_W'(LFSR_W - 1)) begin
                        state_d = HUNT;
                        match_d = '0;
                    end
                end
                HUNT: begin
                    hist_d = {in_bit, hist_q[WIDTH-1:1]};
                    // The all-ones history is the XNOR lockup state and never counts as a match.
                    if ((in_bit == exp_bit) && !lockup) begin
                        match_d = match_q + CNT_W'(1);
                        if (match_d == CNT_W'(LOCK_COUNT)) begin
                            state_d = LOCKED;
                            miss_d  = '0;
                        end
                    end else begin
                        match_d = '0;
                    end
                end
                LOCKED: begin
                    // Free-run on the prediction so a flipped bit cannot corrupt later predictions.
                    hist_d = {exp_bit, hist_q[WIDTH-1:1]};
                    if (in_bit != exp_bit) begin
                        pulse_d = 1'b1;
                        err_inc = 1'b1;
                        miss_d  = miss_q + CNT_W'(1);
                        if (miss_d == CNT_W'(LOSS_COUNT)) begin
                            state_d = FILL;
                            fill_d  = '0;
                            match_d = '0;
                        end
                    end else begin
                        miss_d = '0;
                    end
                end
                default: begin
                    state_d = FILL;
                    fill_d  = '0;
                    match_d = '0;
                end
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= FILL;
            hist_q    <= '0;
            fill_q    <= '0;
            match_q   <= '0;
            miss_q    <= '0;
            locked    <= 1'b0;
            err_pulse <= 1'b0;
        end else begin
            state_q   <= state_d;
            hist_q    <= hist_d;
            fill_q    <= fill_d;
            match_q   <= match_d;
            miss_q    <= miss_d;
            locked    <= (state_d == LOCKED);
            err_pulse <= pulse_d;
        end
    end

    assign state = state_q;

    sat_counter #(.W(ERR_W)) u_err_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (err_inc),
        .clr   (clear_err),
        .count (err_count)
    );

`ifdef LFSR_CHK_STATS_EN
    logic enter_lock;
    logic lose_lock;
    logic bit_inc;

    assign enter_lock = (state_q != LOCKED) && (state_d == LOCKED);
    assign lose_lock  = (state_q == LOCKED) && (state_d == FILL);
    assign bit_inc    = in_valid && (state_q == LOCKED);

    sat_counter #(.W(32)) u_bit_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (bit_inc),
        .clr   (clear_err || enter_lock),
        .count (bit_count)
    );

    sat_counter #(.W(8)) u_loss_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (lose_lock),
        .clr   (1'b0),
        .count (lock_losses)
    );
`endif

endmodule

// File: tb/tb_lfsr_checker.sv
// Scoreboard bench for lfsr_checker: randomized stream/gaps against a behavioural model.
module tb_lfsr_checker;

    localparam int unsigned ERR_W   = 4;
    localparam int          LOCK_N  = 32;
    localparam int          LOSS_N  = 8;
    localparam int          ERR_MAX = 15;

    typedef struct packed {
        logic [1:0]       st;
        logic             pulse;
        logic [ERR_W-1:0] err;
    } exp_t;

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic             in_bit;
    logic             clear_err;
    logic             locked;
    logic [1:0]       state;
    logic             err_pulse;
    logic [ERR_W-1:0] err_count;
`ifdef LFSR_CHK_STATS_EN
    logic [31:0]      bit_count;
    logic [7:0]       lock_losses;
`endif

    lfsr_checker #(
        .WIDTH      (16),
        .LOCK_COUNT (LOCK_N),
        .LOSS_COUNT (LOSS_N),
        .ERR_W      (ERR_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_bit     (in_bit),
        .clear_err  (clear_err),
        .locked     (locked),
        .state      (state),
        .err_pulse  (err_pulse),
`ifdef LFSR_CHK_STATS_EN
        .bit_count  (bit_count),
        .lock_losses(lock_losses),
`endif
        .err_count  (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    int   pulse_seen = 0;
    exp_t sb[$];

    // Reference generator: stream of an XNOR LFSR started from all-zero.
    bit gs[$];
    // Reference checker model (mode 0=FILL, 1=HUNT, 2=LOCKED).
    bit m_h[$];
    int m_mode, m_fill, m_match, m_miss, m_err;
    bit m_pulse;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    function automatic bit gen_next();
        int i = gs.size();
        bit v;
        if (i < 16) v = 1'b0;
        else        v = 1'b1 ^ gs[i-16] ^ gs[i-15] ^ gs[i-13] ^ gs[i-4];
        gs.push_back(v);
        return v;
    endfunction

    function automatic void model_reset();
        m_h.delete();
        for (int i = 0; i < 16; i++) m_h.push_back(1'b0);
        m_mode = 0; m_fill = 0; m_match = 0; m_miss = 0; m_err = 0; m_pulse = 1'b0;
    endfunction

    function automatic void model_shift(input bit b);
        void'(m_h.pop_front());
        m_h.push_back(b);
    endfunction

    function automatic exp_t model_step(input bit v, input bit b, input bit clr);
        exp_t e;
        bit   p;
        bit   ones;
        m_pulse = 1'b0;
        if (v) begin
            p = !(m_h[0] ^ m_h[1] ^ m_h[3] ^ m_h[12]);
            ones = 1'b1;
            foreach (m_h[i]) if (!m_h[i]) ones = 1'b0;
            case (m_mode)
                0: begin
                    model_shift(b);
                    m_fill++;
                    if (m_fill == 16) begin m_mode = 1; m_match = 0; end
                end
                1: begin
                    if (b == p && !ones) m_match++;
                    else                 m_match = 0;
                    model_shift(b);
                    if (m_match == LOCK_N) begin m_mode = 2; m_miss = 0; end
                end
                default: begin
                    if (b != p) begin
                        m_pulse = 1'b1;
                        if (m_err < ERR_MAX) m_err++;
                        m_miss++;
                    end else begin
                        m_miss = 0;
                    end
                    model_shift(p);
                    if (m_miss == LOSS_N) begin m_mode = 0; m_fill = 0; m_match = 0; end
                end
            endcase
        end
        if (clr) m_err = 0;
        e.st    = 2'(m_mode);
        e.pulse = m_pulse;
        e.err   = ERR_W'(m_err);
        return e;
    endfunction

    task automatic drive(input bit v, input bit b, input bit clr);
        exp_t e;
        @(negedge clk);
        in_valid  = v;
        in_bit    = b;
        clear_err = clr;
        e = model_step(v, b, clr);
        sb.push_back(e);
    endtask

    // Send n generator bits, inverting those in [flip_start, flip_start+flip_len).
    task automatic send_bits(input int n, input int flip_start, input int flip_len, input int gap_max);
        bit b;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, gap_max)) drive(1'b0, 1'($urandom), 1'b0);
            b = gen_next();
            if (i >= flip_start && i < flip_start + flip_len) b = ~b;
            drive(1'b1, b, 1'b0);
        end
    endtask

    // Observe the result of the most recent drive.
    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_bit    = 1'b0;
        clear_err = 1'b0;
        repeat (2) @(negedge clk);
        model_reset();
        gs.delete();
        reset = 1'b1;
    endtask

    // Monitor: one expected record per driven cycle.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("sb_state", int'(state), int'(e.st));
                chk("sb_locked", int'(locked), int'(e.st == 2'd2));
                chk("sb_err_pulse", int'(err_pulse), int'(e.pulse));
                chk("sb_err_count", int'(err_count), int'(e.err));
                if (err_pulse) pulse_seen++;
            end
        end
    end

    initial begin
        #1_000_000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion at %0t", $time);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        int p0;
        bit b;
        reset = 1'b0; in_valid = 1'b0; in_bit = 1'b0; clear_err = 1'b0;
        model_reset();
        #2;
        chk("rst_state", int'(state), 0);
        chk("rst_locked", int'(locked), 0);
        chk("rst_err_pulse", int'(err_pulse), 0);
        chk("rst_err_count", int'(err_count), 0);

        // 1: lock acquisition
        do_reset();
        send_bits(16, -1, 0, 0);
        settle();
        chk("s1_hunt_after_16", int'(state), 1);
        send_bits(31, -1, 0, 0);
        settle();
        chk("s1_unlocked_at_47", int'(locked), 0);
        send_bits(1, -1, 0, 0);
        settle();
        chk("s1_locked_at_48", int'(locked), 1);
        send_bits(1000, -1, 0, 0);
        settle();
        chk("s1_err_after_1000", int'(err_count), 0);

        // 2: single flipped bit
        do_reset();
        send_bits(48, -1, 0, 0);
        p0 = pulse_seen;
        send_bits(600, 100, 1, 0);
        settle();
        chk("s2_err_count", int'(err_count), 1);
        chk("s2_pulses", pulse_seen - p0, 1);
        chk("s2_locked", int'(locked), 1);

        // 3: loss of lock and relock
        do_reset();
        send_bits(48, -1, 0, 0);
        send_bits(8, 0, 8, 0);
        settle();
        chk("s3_fill_after_8", int'(state), 0);
        chk("s3_err_count", int'(err_count), 8);
        send_bits(47, -1, 0, 0);
        settle();
        chk("s3_unlocked_at_47", int'(locked), 0);
        send_bits(1, -1, 0, 0);
        settle();
        chk("s3_relocked", int'(locked), 1);
        chk("s3_err_kept", int'(err_count), 8);

        // 4: constant-one stream never locks
        do_reset();
        for (int i = 0; i < 500; i++) drive(1'b1, 1'b1, 1'b0);
        settle();
        chk("s4_state_hunt", int'(state), 1);
        chk("s4_locked", int'(locked), 0);
        chk("s4_err_count", int'(err_count), 0);

        // 5: saturation, then clear coincident with an error
        do_reset();
        send_bits(48, -1, 0, 0);
        for (int w = 0; w < 20; w++) send_bits(10, int'($urandom_range(0, 9)), 1, 0);
        settle();
        chk("s5_saturated", int'(err_count), ERR_MAX);
        chk("s5_locked", int'(locked), 1);
        b = gen_next();
        drive(1'b1, ~b, 1'b1);
        settle();
        chk("s5_clear_wins", int'(err_count), 0);
        chk("s5_pulse_on_clear", int'(err_pulse), 1);

        // 6: random gaps, then asynchronous reset mid-lock
        do_reset();
        send_bits(300, 150, 1, 3);
        settle();
        chk("s6_gap_locked", int'(locked), 1);
        chk("s6_gap_err", int'(err_count), 1);
        #1;
        reset = 1'b0;
        #1;
        chk("s6_async_locked", int'(locked), 0);
        chk("s6_async_state", int'(state), 0);
        chk("s6_async_err", int'(err_count), 0);
        do_reset();
        send_bits(60, -1, 0, 2);
        settle();
        chk("s6_relock_after_reset", int'(locked), 1);

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
        #2;
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lfsr_checker.md
Name: lfsr_checker

Overview:
- Serial pseudo-random sequence checker; the receiving end of the 16-bit XNOR LFSR stream (taps 16,15,13,4; right shift; new bit enters MSB).
- Consumes one stream bit per valid cycle: the bit shifted out of the generator's ps[0].
- Self-synchronises to the stream, then free-runs a local copy of the generator.
- Reports lock status and counts bit errors. Used for on-board verification of random spawn/traffic streams.

Parameters:
- WIDTH, 16: LFSR length. Only 16 is supported because the taps are fixed.
- LOCK_COUNT, 32: consecutive correct predictions in HUNT before declaring lock (1..255).
- LOSS_COUNT, 8: consecutive mismatches in LOCKED before dropping lock (1..255).
- ERR_W, 16: error counter width.

Ports:
- clk  in  1: rising-edge clock.
- reset  in  1: asynchronous, active-low reset.
- in_valid  in  1: in_bit is sampled this cycle.
- in_bit  in  1: received stream bit.
- clear_err  in  1: synchronous clear of err_count.
- locked  out  1: high while in LOCKED.
- state  out  2: FILL=0, HUNT=1, LOCKED=2.
- err_pulse  out  1: one-cycle pulse for each counted mismatch.
- err_count  out  ERR_W: saturating mismatch count.

Behaviour:
- Reset (asynchronous, reset low):
  - hist=0, fill_cnt=0, match_cnt=0, miss_cnt=0.
  - state=FILL, locked=0, err_pulse=0, err_count=0.
  - Applies immediately, including mid-lock.
- hist[15:0] holds the last 16 bits, with hist[i] = s[n+i].
  - Prediction: exp = hist[0] ~^ hist[1] ~^ hist[3] ~^ hist[12].
  - Shift operation: hist <= {b, hist[15:1]}.
- in_valid=0: no state changes; err_pulse=0.
- FILL: each valid bit shifts in_bit into hist and increments fill_cnt. The 16th valid bit moves to HUNT with match_cnt=0. No comparisons are made.
- HUNT: each valid bit compares in_bit with exp, then shifts in in_bit (self-synchronising).
  - Match: match_cnt++.
  - Mismatch: match_cnt=0.
  - A prediction made while hist==16'hFFFF is treated as a mismatch. This is the XNOR lockup state, so a constant-1 stream never locks.
  - When match_cnt reaches LOCK_COUNT: state=LOCKED, miss_cnt=0.
  - HUNT mismatches are not counted as errors.
- LOCKED: each valid bit compares in_bit with exp, then shifts in exp, not in_bit (free-running). A single flipped bit therefore yields exactly one error.
  - Mismatch: err_pulse=1 next cycle, err_count+1 (saturating at all-ones), miss_cnt++.
  - Match: miss_cnt=0.
  - When miss_cnt reaches LOSS_COUNT: state=FILL, fill_cnt=0, match_cnt=0. hist is retained but is refilled before any comparison.
  - All LOSS_COUNT mismatches are counted.
- Latency: all outputs are registered. locked, state, err_pulse and err_count update on the clock edge that samples the deciding bit, so they are visible in the following cycle.
- clear_err=1: err_count becomes 0.
  - Clear has priority over a coincident increment; that error is dropped from the count.
  - err_pulse still fires for that error.
- The outputs are not affected by the gap length between valid bits.

Optional Feature:
- Macro LFSR_CHK_STATS_EN.
- Defined:
  - Adds output bit_count (32-bit): counts valid bits sampled in LOCKED, saturating.
  - Cleared by reset, by clear_err, and on entry to LOCKED.
  - Adds output lock_losses (8-bit, saturating): incremented on each LOCKED->FILL transition; cleared only by reset.
- Undefined: neither port exists and the related logic is absent. All other behaviour is identical.

Decomposition:
- Package lfsr_pkg:
  - LFSR_W=16.
  - Tap index constants 0, 1, 3, 12.
  - Function lfsr_next_bit(logic [15:0]) returning the XNOR prediction.
  - Enum chk_state_t {FILL, HUNT, LOCKED} in 2 bits.
- One sub-module: sat_counter #(W), with inc, clr (clr wins), async active-low reset and count out. Instantiated for err_count, and for bit_count/lock_losses under LFSR_CHK_STATS_EN.

Test Plan:
1. Lock acquisition: drive the stream of a generator reset to all-zero (s[0..15]=0, s[16]=1, ...) with in_valid=1 every cycle. Require state=HUNT after the 16th bit, locked=1 in the cycle after the 48th bit, and err_count=0 over 1000 further bits.
2. Single error: once locked, invert bit 100 only. Require exactly one err_pulse, err_count=1, and locked held for the remaining 500 bits.
3. Loss of lock: once locked, invert 8 consecutive bits. Require err_count=8, state=FILL after the 8th, then relock 48 bits later with the count unchanged.
4. Lockup rejection: drive constant 1 for 500 bits. Require state to remain HUNT, locked=0, err_count=0.
5. Saturation and clear: with ERR_W=4, inject 20 isolated errors (one per 10 bits). Require err_count=15 and locked=1. Then assert clear_err in the same cycle as an error. Require err_count=0 and err_pulse=1.
6. Asynchronous reset: pull reset low mid-lock, between clock edges. Require locked=0, state=FILL and err_count=0 immediately, without waiting for a clock edge. Also run with in_valid gaps of 0–3 cycles and require results identical to scenario 1.
